// File: rtl/change_dispense_sequencer.sv
// Change payout sequencer: greedily ejects 5/2/1-unit coins one at a time over a
// req/ack handshake, tracks hopper inventories and faults on shortfall or hopper timeout.
module change_dispense_sequencer #(
    parameter int AMT_W       = 8,
    parameter int INV_W       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AMT_W-1:0] change_amt,
    input  logic             clear,
    input  logic             load_en,
    input  logic [1:0]       load_sel,
    input  logic [INV_W-1:0] load_cnt,
    output logic [2:0]       eject_req,
    input  logic             eject_ack,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] remaining,
    output logic [INV_W-1:0] inv5,
    output logic [INV_W-1:0] inv2,
    output logic [INV_W-1:0] inv1
);

    localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        EJECT  = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [2:0]       coin_sel;
    logic [2:0]       coin_pick;
    logic [AMT_W-1:0] coin_value;
    logic [TO_W-1:0]  to_cnt;
    logic             timed_out;
    logic             load_ok;

    // Largest denomination that both fits the amount owed and is still in stock.
    always_comb begin
        coin_pick = 3'b000;
        if (remaining >= AMT_W'(5) && inv5 != '0) begin
            coin_pick = 3'b100;
        end else if (remaining >= AMT_W'(2) && inv2 != '0) begin
            coin_pick = 3'b010;
        end else if (remaining >= AMT_W'(1) && inv1 != '0) begin
            coin_pick = 3'b001;
        end
    end

    always_comb begin
        coin_value = AMT_W'(1);
        if (coin_sel[2]) begin
            coin_value = AMT_W'(5);
        end else if (coin_sel[1]) begin
            coin_value = AMT_W'(2);
        end
    end

    assign timed_out = (to_cnt == TO_W'(ACK_TIMEOUT - 1));
    assign load_ok   = load_en && (state == IDLE || state == FAULT);

    // Request is gated by state so an async reset drops it without a clock edge.
    assign eject_req = (state == EJECT) ? coin_sel : 3'b000;
    assign busy      = (state == SELECT) || (state == EJECT);
    assign fault     = (state == FAULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (remaining == '0) begin
                    state_next = IDLE;
                end else if (coin_pick != 3'b000) begin
                    state_next = EJECT;
                end else begin
                    state_next = FAULT;
                end
            end
            EJECT: begin
                if (eject_ack) begin
                    state_next = SELECT;
                end else if (timed_out) begin
                    state_next = FAULT;
                end
            end
            FAULT: begin
                if (clear) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining <= '0;
            done      <= 1'b0;
            coin_sel  <= 3'b000;
            to_cnt    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= change_amt;
                    end
                end
                SELECT: begin
                    if (remaining == '0) begin
                        done <= 1'b1;
                    end else if (coin_pick != 3'b000) begin
                        coin_sel <= coin_pick;
                        to_cnt   <= '0;
                    end
                end
                EJECT: begin
                    if (eject_ack) begin
                        remaining <= remaining - coin_value;
                    end else if (!timed_out) begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end
                FAULT: begin
                    if (clear) begin
                        remaining <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Loads and payout decrements never coincide: loads only land in IDLE/FAULT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv5 <= '0;
            inv2 <= '0;
            inv1 <= '0;
        end else if (load_ok) begin
            case (load_sel)
                2'b00:   inv1 <= load_cnt;
                2'b01:   inv2 <= load_cnt;
                2'b10:   inv5 <= load_cnt;
                default: ;
            endcase
        end else if (state == EJECT && eject_ack) begin
            if (coin_sel[2]) begin
                inv5 <= inv5 - INV_W'(1);
            end else if (coin_sel[1]) begin
                inv2 <= inv2 - INV_W'(1);
            end else begin
                inv1 <= inv1 - INV_W'(1);
            end
        end
    end

endmodule

// File: doc/change_dispense_sequencer.md
Name: change_dispense_sequencer

Overview:
Sequences the coin-return hoppers once a sale has completed and a change amount is known. Breaks the change amount into coin ejections greedily: 5-unit first, then 2-unit, then 1-unit. Drives one hopper at a time with a req/ack handshake and tracks per-hopper inventory. Raises a fault when change cannot be paid or a hopper stops responding. Sits between the vending controller's change output and the three coin hoppers.

Parameters:
AMT_W, 8, width of change amount and remaining counter
INV_W, 8, width of each hopper inventory counter
ACK_TIMEOUT, 16, max cycles eject_req may stay high without eject_ack before fault

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request payout of change_amt; sampled only in IDLE
change_amt  in  AMT_W  change to pay, in 1-unit coins
clear  in  1  leaves FAULT; sampled only in FAULT
load_en  in  1  inventory write strobe; honoured only in IDLE or FAULT
load_sel  in  2  00=1-unit, 01=2-unit, 10=5-unit, 11=ignored
load_cnt  in  INV_W  value written to the selected inventory counter
eject_req  out  3  one-hot hopper request: bit2=5, bit1=2, bit0=1
eject_ack  in  1  hopper has dispensed one coin
busy  out  1  high in every state except IDLE and FAULT
done  out  1  one-cycle pulse when change is fully paid
fault  out  1  level, high while in FAULT
remaining  out  AMT_W  change still owed
inv5, inv2, inv1  out  INV_W each  current hopper inventories

Behaviour:
- Reset (async, rst_n=0): state=IDLE; eject_req=0; busy=0; done=0; fault=0; remaining=0; all inv*=0; timeout counter=0. Reset mid-payout abandons the payout immediately; the hopper sees req drop asynchronously.
- States: IDLE, SELECT, EJECT, FAULT.
- IDLE:
  - start=1 at an edge: remaining<=change_amt, busy<=1, go to SELECT.
  - load_en in the same cycle as start: load takes effect and start is honoured; SELECT sees the new inventory.
- SELECT (one cycle, combinational decision, registered outputs):
  - remaining==0: done=1 for exactly one cycle, busy<=0, go to IDLE.
  - Otherwise choose the largest d in {5,2,1} with d<=remaining and inv_d>0. Assert the matching eject_req bit, clear the timeout counter, go to EJECT.
  - No eligible d: go to FAULT. remaining keeps the unpaid amount.
- EJECT:
  - eject_req is held stable and one-hot.
  - eject_ack=1 at an edge: remaining-=d, inv_d-=1, eject_req<=0, go to SELECT. eject_req is therefore low for at least one cycle between coins.
  - Otherwise the timeout counter increments. When it reaches ACK_TIMEOUT-1 without ack: eject_req<=0, go to FAULT. Inventory and remaining are not decremented.
  - eject_ack seen outside EJECT is ignored.
- FAULT:
  - fault=1, busy=0, eject_req=0.
  - load_en is allowed.
  - clear=1: fault<=0, remaining<=0, go to IDLE.
  - start is ignored.
- Latency: start edge k puts SELECT in cycle k+1; eject_req is high from edge k+2. ack at edge m gives the next eject_req at edge m+2. change_amt=0 gives done at edge k+2.
- Arithmetic: no wrap is possible. Decrements only occur when d<=remaining and inv_d>=1.
- load_en during SELECT or EJECT is dropped silently. load_sel=11 is a no-op.
- Exactly one eject_req bit is ever high.

Test Plan:
- Load inv5=2, inv2=2, inv1=3; start change_amt=8; ack each req after 2 cycles -> reqs 100, 010, 001 in order. done pulses once; remaining=0; inv5=1, inv2=1, inv1=2.
- inv5=0, inv2=1, inv1=5; change_amt=7 -> reqs 010, then 001 five times. done pulses; inv2=0, inv1=0.
- inv5=1, inv2=0, inv1=1; change_amt=8 -> ejects 5, then 1, then FAULT with remaining=2. clear returns to IDLE with remaining=0.
- Hopper never acks on first req with ACK_TIMEOUT=16 -> eject_req high 16 cycles, then 0. fault=1; inventory unchanged.
- change_amt=0 -> done pulse 2 cycles after start; no eject_req.
- Assert rst_n=0 during EJECT -> eject_req drops without waiting for clk. All outputs and inventories read 0; load_en pulsed mid-EJECT has no effect.
